// File: rtl/axi_line_fill_ctrl.sv
// axi_line_fill_ctrl: fills one cache line through a single AXI4 INCR read burst
module axi_line_fill_ctrl #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 16,
   parameter int LINE_WORDS = 128,
   parameter int IDX_W      = $clog2(LINE_WORDS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  fill_we,
   output logic [IDX_W-1:0]      fill_idx,
   output logic [DATA_WIDTH-1:0] fill_data,
   output logic                  done,
   output logic                  err,
   output logic [ID_WIDTH-1:0]   arid_m_inf,
   output logic [ADDR_WIDTH-1:0] araddr_m_inf,
   output logic [6:0]            arlen_m_inf,
   output logic [2:0]            arsize_m_inf,
   output logic [1:0]            arburst_m_inf,
   output logic                  arvalid_m_inf,
   input  logic                  arready_m_inf,
   input  logic [ID_WIDTH-1:0]   rid_m_inf,
   input  logic [DATA_WIDTH-1:0] rdata_m_inf,
   input  logic [1:0]            rresp_m_inf,
   input  logic                  rlast_m_inf,
   input  logic                  rvalid_m_inf,
   output logic                  rready_m_inf
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;
   localparam logic [IDX_W:0]      LAST_CNT  = (IDX_W+1)'(LINE_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH)'(LINE_WORDS * 2 - 1));
   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [IDX_W:0]        cnt_q, cnt_d;
   logic                  err_flag_q, err_flag_d;
   logic                  req_ready_q, req_ready_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic                  fill_we_q, fill_we_d;
   logic [IDX_W-1:0]      fill_idx_q, fill_idx_d;
   logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  beat, last_beat, beat_err;
   assign arid_m_inf    = '0;
   assign arlen_m_inf   = 7'(LINE_WORDS - 1);
   assign arsize_m_inf  = 3'b001;
   assign arburst_m_inf = 2'b01;
   assign araddr_m_inf  = araddr_q;
   assign arvalid_m_inf = arvalid_q;
   assign rready_m_inf  = rready_q;
   assign req_ready     = req_ready_q;
   assign fill_we       = fill_we_q;
   assign fill_idx      = fill_idx_q;
   assign fill_data     = fill_data_q;
   assign done          = done_q;
   assign err           = err_q;
   // next state; handshake outputs are derived from the next state so they are registered
   always_comb begin
      state_d     = state_q;
      araddr_d    = araddr_q;
      cnt_d       = cnt_q;
      err_flag_d  = err_flag_q;
      fill_we_d   = 1'b0;
      fill_idx_d  = fill_idx_q;
      fill_data_d = fill_data_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      beat        = rvalid_m_inf && rready_q;
      last_beat   = rlast_m_inf || cnt_q == LAST_CNT;
      beat_err    = rresp_m_inf != 2'b00 || rid_m_inf != '0 ||
                    (rlast_m_inf && cnt_q < LAST_CNT) || (!rlast_m_inf && cnt_q == LAST_CNT);
      case (state_q)
         IDLE: if (req_valid) begin
            state_d    = ADDR;
            araddr_d   = req_addr & LINE_MASK;
            cnt_d      = '0;
            err_flag_d = 1'b0;
         end
         ADDR: state_d = arready_m_inf ? DATA : ADDR;
         DATA: if (beat) begin
            fill_we_d   = 1'b1;
            fill_idx_d  = cnt_q[IDX_W-1:0];
            fill_data_d = rdata_m_inf;
            cnt_d       = cnt_q + 1'b1;
            err_flag_d  = err_flag_q || beat_err;
            state_d     = last_beat ? DONE : DATA;
            done_d      = last_beat;
            err_d       = last_beat && err_flag_d;
         end
         default: state_d = IDLE;
      endcase
      req_ready_d = state_d == IDLE;
      arvalid_d   = state_d == ADDR;
      rready_d    = state_d == DATA;
   end
   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         araddr_q    <= '0;
         cnt_q       <= '0;
         err_flag_q  <= 1'b0;
         req_ready_q <= 1'b1;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         fill_we_q   <= 1'b0;
         fill_idx_q  <= '0;
         fill_data_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         araddr_q    <= araddr_d;
         cnt_q       <= cnt_d;
         err_flag_q  <= err_flag_d;
         req_ready_q <= req_ready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         fill_we_q   <= fill_we_d;
         fill_idx_q  <= fill_idx_d;
         fill_data_q <= fill_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end
endmodule

// File: tb/tb_axi_line_fill_ctrl.sv
// tb_axi_line_fill_ctrl: directed line fills against a 4-word line with a scripted AXI slave
module tb_axi_line_fill_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        fill_we;
   logic [1:0]  fill_idx;
   logic [15:0] fill_data;
   logic        done, err;
   logic [3:0]  arid_m_inf;
   logic [31:0] araddr_m_inf;
   logic [6:0]  arlen_m_inf;
   logic [2:0]  arsize_m_inf;
   logic [1:0]  arburst_m_inf;
   logic        arvalid_m_inf;
   logic        arready_m_inf = 1'b0;
   logic [3:0]  rid_m_inf = '0;
   logic [15:0] rdata_m_inf = '0;
   logic [1:0]  rresp_m_inf = '0;
   logic        rlast_m_inf = 1'b0;
   logic        rvalid_m_inf = 1'b0;
   logic        rready_m_inf;
   int          n_tests = 0;
   int          n_fail = 0;

   axi_line_fill_ctrl #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(16), .LINE_WORDS(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data), .done(done), .err(err),
      .arid_m_inf(arid_m_inf), .araddr_m_inf(araddr_m_inf), .arlen_m_inf(arlen_m_inf),
      .arsize_m_inf(arsize_m_inf), .arburst_m_inf(arburst_m_inf), .arvalid_m_inf(arvalid_m_inf),
      .arready_m_inf(arready_m_inf), .rid_m_inf(rid_m_inf), .rdata_m_inf(rdata_m_inf),
      .rresp_m_inf(rresp_m_inf), .rlast_m_inf(rlast_m_inf), .rvalid_m_inf(rvalid_m_inf),
      .rready_m_inf(rready_m_inf)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One fill, driven and sampled on falling edges. Beat b carries 0xA000+b.
   task automatic fill(input logic [31:0] addr, input int ar_dly, input int g0, input int g1,
                       input int g2, input int g3, input int bad_resp, input int bad_id,
                       input int last_at, input int n_beats, input logic exp_err, input bit hold,
                       input logic [31:0] next_addr, input bit abort);
      int   gap [4];
      int   t;
      logic fin;
      gap = '{g0, g1, g2, g3};
      t = 0;
      req_valid = 1'b1;
      req_addr  = addr;
      while (!arvalid_m_inf && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("arvalid_up", 32'(arvalid_m_inf), 32'd1);
      check("req_ready_busy", 32'(req_ready), 32'd0);
      check("araddr", araddr_m_inf, addr & ~32'h7);
      check("ar_const", 32'({arid_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf}),
            32'({4'h0, 7'd3, 3'd1, 2'd1}));
      if (!hold) req_valid = 1'b0;
      repeat (ar_dly) begin
         @(negedge clk);
         check("arvalid_hold", 32'(arvalid_m_inf), 32'd1);
         check("araddr_hold", araddr_m_inf, addr & ~32'h7);
      end
      arready_m_inf = 1'b1;
      @(negedge clk);
      arready_m_inf = 1'b0;
      check("arvalid_drop", 32'(arvalid_m_inf), 32'd0);
      check("rready_up", 32'(rready_m_inf), 32'd1);
      for (int b = 0; b < n_beats; b++) begin
         rvalid_m_inf = 1'b0;
         for (int g = 0; g < gap[b]; g++) begin
            @(negedge clk);
            check("we_in_gap", 32'(fill_we), 32'd0);
         end
         rvalid_m_inf = 1'b1;
         rdata_m_inf  = 16'hA000 + 16'(b);
         rresp_m_inf  = (b == bad_resp) ? 2'b10 : 2'b00;
         rid_m_inf    = (b == bad_id) ? 4'h3 : 4'h0;
         rlast_m_inf  = (b == last_at);
         @(negedge clk);
         fin = !abort && b == n_beats - 1;
         check("fill_we", 32'(fill_we), 32'd1);
         check("fill_idx", 32'(fill_idx), 32'(b));
         check("fill_data", 32'(fill_data), 32'hA000 + 32'(b));
         check("done", 32'(done), 32'(fin));
         check("err", 32'(err), 32'(fin && exp_err));
      end
      if (!abort) begin
         check("rready_drop", 32'(rready_m_inf), 32'd0);
         if (hold) req_addr = next_addr;
         rdata_m_inf  = 16'hBEEF;
         rresp_m_inf  = 2'b00;
         rid_m_inf    = 4'h0;
         rlast_m_inf  = 1'b1;
         rvalid_m_inf = 1'b1;
         @(negedge clk);
         check("stray_beat_we", 32'(fill_we), 32'd0);
         check("done_pulse_end", 32'(done), 32'd0);
         check("err_after_done", 32'(err), 32'd0);
         check("req_ready_back", 32'(req_ready), 32'd1);
         check("arvalid_idle", 32'(arvalid_m_inf), 32'd0);
         rvalid_m_inf = 1'b0;
         rlast_m_inf  = 1'b0;
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_arvalid", 32'(arvalid_m_inf), 32'd0);
      check("rst_rready", 32'(rready_m_inf), 32'd0);
      check("rst_fill_we", 32'(fill_we), 32'd0);
      check("rst_done_err", 32'({done, err}), 32'd0);
      check("rst_fill_idx_data", 32'({fill_idx, fill_data}), 32'd0);
      check("rst_araddr", araddr_m_inf, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      // nominal
      fill(32'h0000_1236, 2, 0, 0, 0, 0, -1, -1, 3, 4, 1'b0, 1'b0, 32'd0, 1'b0);
      // stalled data
      fill(32'h0000_2000, 0, 0, 3, 1, 5, -1, -1, 3, 4, 1'b0, 1'b0, 32'd0, 1'b0);
      // SLVERR on beat 1
      fill(32'h0000_3458, 1, 0, 0, 0, 0, 1, -1, 3, 4, 1'b1, 1'b0, 32'd0, 1'b0);
      // wrong ID on beat 0
      fill(32'h0000_4000, 0, 1, 0, 0, 0, -1, 0, 3, 4, 1'b1, 1'b0, 32'd0, 1'b0);
      // early rlast on beat 1
      fill(32'h0000_5002, 0, 0, 0, 0, 0, -1, -1, 1, 2, 1'b1, 1'b0, 32'd0, 1'b0);
      // missing rlast
      fill(32'h0000_6004, 0, 0, 0, 0, 0, -1, -1, -1, 4, 1'b1, 1'b0, 32'd0, 1'b0);
      // back-to-back with the request held high
      fill(32'h0000_7006, 1, 0, 0, 0, 0, -1, -1, 3, 4, 1'b0, 1'b1, 32'h0000_811F, 1'b0);
      @(negedge clk);
      check("b2b_arvalid_2_after_done", 32'(arvalid_m_inf), 32'd1);
      check("b2b_araddr", araddr_m_inf, 32'h0000_8118);
      fill(32'h0000_811F, 0, 0, 0, 0, 0, -1, -1, 3, 4, 1'b0, 1'b0, 32'd0, 1'b0);
      // async reset after two beats, off the clock edge
      fill(32'h0000_9000, 0, 0, 0, 0, 0, -1, -1, 3, 2, 1'b0, 1'b0, 32'd0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_arvalid", 32'(arvalid_m_inf), 32'd0);
      check("arst_rready", 32'(rready_m_inf), 32'd0);
      check("arst_fill_we", 32'(fill_we), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_req_ready", 32'(req_ready), 32'd1);
      rvalid_m_inf = 1'b0;
      rlast_m_inf  = 1'b0;
      rresp_m_inf  = 2'b00;
      rid_m_inf    = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      fill(32'h0000_A00A, 1, 0, 2, 0, 0, -1, -1, 3, 4, 1'b0, 1'b0, 32'd0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
